// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32 core (lw, sw, R, I, beq, jal).
// Optional `MAIN_FSM_MEM_READY_EN adds the mem_ready port and wait states in FETCH/MEMREAD/MEMWRITE.
module multicycle_main_fsm #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
`ifdef MAIN_FSM_MEM_READY_EN
  input  logic       mem_ready,
`endif
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       mem_write,
  output logic       reg_write,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t r_state;
  logic   r_illegal;
  logic   w_ready;
  logic   w_ir_en;
  logic   w_pc_update;
  logic   w_mem_wr;
  logic   w_reg_wr;

`ifdef MAIN_FSM_MEM_READY_EN
  assign w_ready = mem_ready;
`else
  assign w_ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        FETCH:    if (w_ready) r_state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LW, OP_SW: r_state <= MEMADR;
            OP_R:         r_state <= EXECUTER;
            OP_I:         r_state <= EXECUTEI;
            OP_BEQ:       r_state <= BEQ;
            OP_JAL:       r_state <= JAL;
            default: begin
              if (TRAP_ON_ILLEGAL) begin
                r_state   <= TRAP;
                r_illegal <= 1'b1;
              end else begin
                r_state <= FETCH;
              end
            end
          endcase
        end
        MEMADR:   r_state <= (opcode == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  if (w_ready) r_state <= MEMWB;
        MEMWRITE: if (w_ready) r_state <= FETCH;
        EXECUTER, EXECUTEI, JAL: r_state <= ALUWB;
        MEMWB, ALUWB, BEQ:       r_state <= FETCH;
        TRAP:     r_state <= TRAP;
        default:  r_state <= FETCH;
      endcase
    end
  end

  always_comb begin
    alu_op      = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    adr_src     = 1'b0;
    branch      = 1'b0;
    w_ir_en     = 1'b0;
    w_pc_update = 1'b0;
    w_mem_wr    = 1'b0;
    w_reg_wr    = 1'b0;
    case (r_state)
      FETCH: begin
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        w_ir_en     = w_ready;
        w_pc_update = w_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        w_reg_wr   = 1'b1;
      end
      MEMWRITE: begin
        adr_src  = 1'b1;
        w_mem_wr = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB:    w_reg_wr = 1'b1;
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        w_pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are suppressed for the whole reset cycle, not just after the edge.
  assign ir_write      = w_ir_en & ~reset;
  assign pc_write      = (w_pc_update | (branch & zero)) & ~reset;
  assign mem_write     = w_mem_wr & ~reset;
  assign reg_write     = w_reg_wr & ~reset;
  assign illegal_instr = r_illegal;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: instruction-level micro-step model, two DUTs
// (TRAP_ON_ILLEGAL=1 and =0); mem_ready scenarios run when MAIN_FSM_MEM_READY_EN is defined.
module tb_multicycle_main_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef enum int {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXR, S_EXI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } step_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic [1:0] a_alu_op, a_src_a, a_src_b, a_res;
  logic       a_adr, a_ir, a_pc, a_br, a_mw, a_rw, a_ill;
  logic [1:0] b_alu_op, b_src_a, b_src_b, b_res;
  logic       b_adr, b_ir, b_pc, b_br, b_mw, b_rw, b_ill;
  logic [14:0] w_obs_a, w_obs_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_main_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
`ifdef MAIN_FSM_MEM_READY_EN
    .mem_ready(mem_ready),
`endif
    .alu_op(a_alu_op), .alu_src_a(a_src_a), .alu_src_b(a_src_b), .result_src(a_res),
    .adr_src(a_adr), .ir_write(a_ir), .pc_write(a_pc), .branch(a_br),
    .mem_write(a_mw), .reg_write(a_rw), .illegal_instr(a_ill)
  );

  multicycle_main_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
`ifdef MAIN_FSM_MEM_READY_EN
    .mem_ready(mem_ready),
`endif
    .alu_op(b_alu_op), .alu_src_a(b_src_a), .alu_src_b(b_src_b), .result_src(b_res),
    .adr_src(b_adr), .ir_write(b_ir), .pc_write(b_pc), .branch(b_br),
    .mem_write(b_mw), .reg_write(b_rw), .illegal_instr(b_ill)
  );

  assign w_obs_a = {a_alu_op, a_src_a, a_src_b, a_res, a_adr, a_ir, a_pc, a_br, a_mw, a_rw, a_ill};
  assign w_obs_b = {b_alu_op, b_src_a, b_src_b, b_res, b_adr, b_ir, b_pc, b_br, b_mw, b_rw, b_ill};

  // Output table of each micro-step: {alu_op,src_a,src_b,result_src,adr,ir,pc,branch,mem_wr,reg_wr,illegal}
  function automatic logic [14:0] exp_out(step_t s, logic z, logic rdy, logic rst, logic ill);
    logic [1:0] op, sa, sb, rs;
    logic adr, ir, pc, br, mw, rw;
    {op, sa, sb, rs, adr, ir, pc, br, mw, rw} = '0;
    case (s)
      S_FETCH:    begin sb = 2'b10; rs = 2'b10; ir = rdy; pc = rdy; end
      S_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      S_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      S_MEMREAD:  adr = 1'b1;
      S_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
      S_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
      S_EXR:      begin sa = 2'b10; op = 2'b10; end
      S_EXI:      begin sa = 2'b10; sb = 2'b01; op = 2'b10; end
      S_ALUWB:    rw = 1'b1;
      S_BEQ:      begin sa = 2'b10; op = 2'b01; br = 1'b1; pc = z; end
      S_JAL:      begin sa = 2'b01; sb = 2'b10; pc = 1'b1; end
      default:    ;
    endcase
    if (rst) begin ir = 1'b0; pc = 1'b0; mw = 1'b0; rw = 1'b0; end
    return {op, sa, sb, rs, adr, ir, pc, br, mw, rw, ill};
  endfunction

  function automatic void instr_steps(input logic [6:0] opc, output step_t q[$]);
    q = {};
    q.push_back(S_FETCH);
    q.push_back(S_DECODE);
    case (opc)
      OP_LW:  begin q.push_back(S_MEMADR); q.push_back(S_MEMREAD); q.push_back(S_MEMWB); end
      OP_SW:  begin q.push_back(S_MEMADR); q.push_back(S_MEMWRITE); end
      OP_R:   begin q.push_back(S_EXR); q.push_back(S_ALUWB); end
      OP_I:   begin q.push_back(S_EXI); q.push_back(S_ALUWB); end
      OP_BEQ: q.push_back(S_BEQ);
      OP_JAL: begin q.push_back(S_JAL); q.push_back(S_ALUWB); end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one legal instruction from FETCH; opcode is junk outside the cycles that sample it.
  task automatic drive_instr(input logic [6:0] opc, input logic z, input int fwait, input int mwait,
                             output logic [14:0] ex[$], output logic [14:0] oa[$],
                             output logic [14:0] ob[$]);
    step_t st[$];
    instr_steps(opc, st);
    ex = {}; oa = {}; ob = {};
    foreach (st[k]) begin
      int waits = 0;
`ifdef MAIN_FSM_MEM_READY_EN
      if (st[k] == S_FETCH)
        waits = (fwait < 0) ? int'($urandom_range(0, 2)) : fwait;
      else if (st[k] == S_MEMREAD || st[k] == S_MEMWRITE)
        waits = (mwait < 0) ? int'($urandom_range(0, 2)) : mwait;
`endif
      for (int w = 0; w <= waits; w++) begin
        mem_ready = (w == waits);
        opcode    = (st[k] == S_DECODE || st[k] == S_MEMADR) ? opc : 7'($urandom);
        zero      = (st[k] == S_BEQ) ? z : 1'($urandom);
        #4;
        ex.push_back(exp_out(st[k], zero, mem_ready, 1'b0, 1'b0));
        oa.push_back(w_obs_a);
        ob.push_back(w_obs_b);
        tick();
      end
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [14:0] e;
    reset = 1'b1;
    mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      opcode = 7'($urandom);
      #4;
      e = exp_out(S_FETCH, zero, mem_ready, 1'b1, 1'b0);
      checks++;
      if (w_obs_a !== e) begin errors++; $display("FAIL reset[%0d] trap-dut got=%b exp=%b", c, w_obs_a, e); end
      checks++;
      if (w_obs_b !== e) begin errors++; $display("FAIL reset[%0d] nop-dut got=%b exp=%b", c, w_obs_b, e); end
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_rtype_itype();
    logic [14:0] ex[$], oa[$], ob[$];
    logic [6:0] ops[2];
    ops[0] = OP_R;
    ops[1] = OP_I;
    foreach (ops[i]) begin
      drive_instr(ops[i], 1'b0, 0, 0, ex, oa, ob);
      foreach (ex[k]) begin
        checks++;
        if (oa[k] !== ex[k]) begin errors++; $display("FAIL alu_instr%0d[%0d] trap-dut got=%b exp=%b", i, k, oa[k], ex[k]); end
        checks++;
        if (ob[k] !== ex[k]) begin errors++; $display("FAIL alu_instr%0d[%0d] nop-dut got=%b exp=%b", i, k, ob[k], ex[k]); end
      end
    end
  endtask

  task automatic test_load_store();
    logic [14:0] ex[$], oa[$], ob[$];
    int mw_cnt;
    drive_instr(OP_LW, 1'b0, 0, 0, ex, oa, ob);
    foreach (ex[k]) begin
      checks++;
      if (oa[k] !== ex[k]) begin errors++; $display("FAIL lw[%0d] got=%b exp=%b", k, oa[k], ex[k]); end
    end
    drive_instr(OP_SW, 1'b0, 0, 0, ex, oa, ob);
    mw_cnt = 0;
    foreach (ex[k]) begin
      mw_cnt += int'(oa[k][2]);
      checks++;
      if (oa[k] !== ex[k]) begin errors++; $display("FAIL sw[%0d] got=%b exp=%b", k, oa[k], ex[k]); end
    end
    checks++;
    if (mw_cnt !== 1) begin errors++; $display("FAIL sw_mem_write_cycles got=%0d exp=1", mw_cnt); end
  endtask

  task automatic test_beq();
    logic [14:0] ex[$], oa[$], ob[$];
    for (int z = 1; z >= 0; z--) begin
      drive_instr(OP_BEQ, 1'(z), 0, 0, ex, oa, ob);
      foreach (ex[k]) begin
        checks++;
        if (oa[k] !== ex[k]) begin errors++; $display("FAIL beq_z%0d[%0d] got=%b exp=%b", z, k, oa[k], ex[k]); end
      end
    end
  endtask

  task automatic test_jal();
    logic [14:0] ex[$], oa[$], ob[$];
    drive_instr(OP_JAL, 1'b0, 0, 0, ex, oa, ob);
    foreach (ex[k]) begin
      checks++;
      if (oa[k] !== ex[k]) begin errors++; $display("FAIL jal[%0d] trap-dut got=%b exp=%b", k, oa[k], ex[k]); end
      checks++;
      if (ob[k] !== ex[k]) begin errors++; $display("FAIL jal[%0d] nop-dut got=%b exp=%b", k, ob[k], ex[k]); end
    end
  endtask

  task automatic test_illegal();
    logic [14:0] ea, eb;
    mem_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      opcode = OP_BAD;
      zero   = 1'($urandom);
      #4;
      ea = (k == 0) ? exp_out(S_FETCH, zero, 1'b1, 1'b0, 1'b0) :
           (k == 1) ? exp_out(S_DECODE, zero, 1'b1, 1'b0, 1'b0) :
                      exp_out(S_TRAP, zero, 1'b1, 1'b0, 1'b1);
      eb = (k % 2 == 0) ? exp_out(S_FETCH, zero, 1'b1, 1'b0, 1'b0) :
                          exp_out(S_DECODE, zero, 1'b1, 1'b0, 1'b0);
      checks++;
      if (w_obs_a !== ea) begin errors++; $display("FAIL trap[%0d] got=%b exp=%b", k, w_obs_a, ea); end
      checks++;
      if (w_obs_b !== eb) begin errors++; $display("FAIL illegal_nop[%0d] got=%b exp=%b", k, w_obs_b, eb); end
      tick();
    end
    reset = 1'b1;
    #4;
    ea = exp_out(S_TRAP, zero, 1'b1, 1'b1, 1'b1);
    checks++;
    if (w_obs_a !== ea) begin errors++; $display("FAIL trap_in_reset got=%b exp=%b", w_obs_a, ea); end
    tick();
    #4;
    ea = exp_out(S_FETCH, zero, 1'b1, 1'b1, 1'b0);
    checks++;
    if (w_obs_a !== ea) begin errors++; $display("FAIL trap_cleared got=%b exp=%b", w_obs_a, ea); end
    checks++;
    if (w_obs_b !== ea) begin errors++; $display("FAIL nop_after_reset got=%b exp=%b", w_obs_b, ea); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [14:0] e;
    mem_ready = 1'b1;
    opcode = OP_SW;
    for (int k = 0; k < 3; k++) tick();
`ifdef MAIN_FSM_MEM_READY_EN
    mem_ready = 1'b0;
    #4;
    e = exp_out(S_MEMWRITE, zero, 1'b0, 1'b0, 1'b0);
    checks++;
    if (w_obs_a !== e) begin errors++; $display("FAIL memwrite_wait got=%b exp=%b", w_obs_a, e); end
    tick();
`endif
    reset = 1'b1;
    opcode = 7'($urandom);
    #4;
    e = exp_out(S_MEMWRITE, zero, mem_ready, 1'b1, 1'b0);
    checks++;
    if (w_obs_a !== e) begin errors++; $display("FAIL reset_mid_memwrite got=%b exp=%b", w_obs_a, e); end
    tick();
    #4;
    e = exp_out(S_FETCH, zero, mem_ready, 1'b1, 1'b0);
    checks++;
    if (w_obs_a !== e) begin errors++; $display("FAIL reset_mid_to_fetch got=%b exp=%b", w_obs_a, e); end
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
  endtask

`ifdef MAIN_FSM_MEM_READY_EN
  task automatic test_mem_ready();
    logic [14:0] ex[$], oa[$], ob[$];
    int mw_cnt;
    drive_instr(OP_R, 1'b0, 3, 0, ex, oa, ob);
    foreach (ex[k]) begin
      checks++;
      if (oa[k] !== ex[k]) begin errors++; $display("FAIL fetch_wait[%0d] got=%b exp=%b", k, oa[k], ex[k]); end
    end
    drive_instr(OP_LW, 1'b0, 0, 2, ex, oa, ob);
    foreach (ex[k]) begin
      checks++;
      if (oa[k] !== ex[k]) begin errors++; $display("FAIL lw_wait[%0d] got=%b exp=%b", k, oa[k], ex[k]); end
    end
    drive_instr(OP_SW, 1'b0, 0, 2, ex, oa, ob);
    mw_cnt = 0;
    foreach (ex[k]) begin
      mw_cnt += int'(oa[k][2]);
      checks++;
      if (oa[k] !== ex[k]) begin errors++; $display("FAIL sw_wait[%0d] got=%b exp=%b", k, oa[k], ex[k]); end
    end
    checks++;
    if (mw_cnt !== 3) begin errors++; $display("FAIL sw_wait_mem_write_cycles got=%0d exp=3", mw_cnt); end
  endtask
`endif

  task automatic test_random();
    logic [14:0] ex[$], oa[$], ob[$];
    logic [6:0] legal[6];
    logic [6:0] opc;
    legal[0] = OP_LW; legal[1] = OP_SW; legal[2] = OP_R;
    legal[3] = OP_I;  legal[4] = OP_BEQ; legal[5] = OP_JAL;
    for (int n = 0; n < 40; n++) begin
      opc = legal[$urandom_range(0, 5)];
      drive_instr(opc, 1'($urandom), -1, -1, ex, oa, ob);
      foreach (ex[k]) begin
        checks++;
        if (oa[k] !== ex[k]) begin errors++; $display("FAIL random%0d op=%b [%0d] got=%b exp=%b", n, opc, k, oa[k], ex[k]); end
        checks++;
        if (ob[k] !== ex[k]) begin errors++; $display("FAIL random%0d op=%b nop-dut [%0d] got=%b exp=%b", n, opc, k, ob[k], ex[k]); end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rtype_itype();
    test_load_store();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid();
`ifdef MAIN_FSM_MEM_READY_EN
    test_mem_ready();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
